// File: rtl/iomem_uart_master.sv
// Byte-stream to iomem bridge: decodes 'R'/'W' command frames from a UART receiver,
// runs one bus cycle with a timeout, and streams ACK/NAK/read data back to the transmitter.
module iomem_uart_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLKOUT,
    input  logic        resetn,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_data,
    output logic        cmd_ready,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    input  logic        rsp_ready,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic        busy,
    output logic [2:0]  dbg_state
);
    // Handshakes: a byte moves on a rising CLKOUT edge where valid && ready are both high;
    // the producer holds valid and data stable until that edge.

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    state_t        state_q, state_n;
    logic [1:0]    byte_cnt;
    logic [CW-1:0] tmo_cnt;
    logic [2:0]    rsp_cnt;
    logic [39:0]   rsp_buf;
    logic          is_write;

    logic cmd_fire, rsp_fire, op_ok, last_byte, bus_done, bus_tmo;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign op_ok     = (cmd_data == 8'h52) || (cmd_data == 8'h57);
    assign last_byte = (byte_cnt == 2'd3);
    assign bus_done  = iomem_valid && iomem_ready;
    assign bus_tmo   = iomem_valid && !iomem_ready && (tmo_cnt == CW'(TIMEOUT - 1));

    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_buf[39:32];
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: if (cmd_fire) state_n = op_ok ? ADDR : RESP;
            ADDR: if (cmd_fire && last_byte) state_n = is_write ? DATA : BUS;
            DATA: if (cmd_fire && last_byte) state_n = BUS;
            BUS:  if (bus_done || bus_tmo) state_n = RESP;
            RESP: if (rsp_fire && (rsp_cnt == 3'd1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLKOUT) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cmd_ready <= 1'b0;
        end else begin
            state_q   <= state_n;
            // Registered so it stays low through reset and rises one edge after release.
            cmd_ready <= (state_n == IDLE) || (state_n == ADDR) || (state_n == DATA);
        end
    end

    always_ff @(posedge CLKOUT) begin
        if (!resetn) begin
            iomem_valid <= 1'b0;
            iomem_wstrb <= 4'h0;
            iomem_addr  <= 32'h0;
            iomem_wdata <= 32'h0;
            byte_cnt    <= 2'd0;
            tmo_cnt     <= '0;
            rsp_cnt     <= 3'd0;
            rsp_buf     <= 40'h0;
            is_write    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (cmd_fire) begin
                    is_write <= (cmd_data == 8'h57);
                    byte_cnt <= 2'd0;
                    if (!op_ok) begin
                        rsp_buf <= {8'h3F, 32'h0};
                        rsp_cnt <= 3'd1;
                    end
                end
                ADDR: if (cmd_fire) begin
                    iomem_addr <= {iomem_addr[23:0], cmd_data};
                    byte_cnt   <= byte_cnt + 2'd1;
                    if (last_byte && !is_write) begin
                        iomem_wstrb <= 4'h0;
                        tmo_cnt     <= '0;
                    end
                end
                DATA: if (cmd_fire) begin
                    iomem_wdata <= {iomem_wdata[23:0], cmd_data};
                    byte_cnt    <= byte_cnt + 2'd1;
                    if (last_byte) begin
                        iomem_wstrb <= 4'hF;
                        tmo_cnt     <= '0;
                    end
                end
                BUS: begin
                    if (!iomem_valid) begin
                        iomem_valid <= 1'b1;
                    end else if (iomem_ready) begin
                        // Ready wins even on the final counted cycle.
                        iomem_valid <= 1'b0;
                        rsp_buf     <= {8'h06, is_write ? 32'h0 : iomem_rdata};
                        rsp_cnt     <= is_write ? 3'd1 : 3'd5;
                    end else if (bus_tmo) begin
                        iomem_valid <= 1'b0;
                        rsp_buf     <= {8'h15, 32'h0};
                        rsp_cnt     <= 3'd1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: if (rsp_fire) begin
                    rsp_buf <= {rsp_buf[31:0], 8'h00};
                    rsp_cnt <= rsp_cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_iomem_uart_master.sv
// Bench for iomem_uart_master: directed vector table, hand-written corner sequences,
// and random frames scored against a frame-level reference model.
module tb_iomem_uart_master;
    localparam int TMO = 8;

    logic        CLKOUT = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_data = 8'h00;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_ready = 1'b0;
    logic        iomem_valid;
    logic        iomem_ready = 1'b0;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata = 32'h0;
    logic        busy;
    logic [2:0]  dbg_state;

    iomem_uart_master #(.TIMEOUT(TMO)) dut (
        .CLKOUT(CLKOUT), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 CLKOUT = ~CLKOUT;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [67:0] bus_q[$];
    int          vlen_q[$];
    int          r_delay = 1000;
    logic [31:0] r_data = 32'h0;
    int          vrun = 0;
    int          bp_hold = 0;
    bit          bp_rand = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // bus responder: answers in valid cycle index r_delay, logs each request and its valid length
    always @(negedge CLKOUT) begin
        if (!iomem_valid) begin
            if (vrun > 0) vlen_q.push_back(vrun);
            vrun = 0;
            iomem_ready = 1'b0;
        end else begin
            checks++;
            if (cmd_ready) begin
                errors++;
                $display("FAIL valid_with_cmd_ready actual=1 required=0");
            end
            if (vrun == 0) begin
                bus_q.push_back({iomem_addr, iomem_wdata, iomem_wstrb});
            end else if (bus_q.size() > 0) begin
                checks++;
                if ({iomem_addr, iomem_wdata, iomem_wstrb} !== bus_q[$]) begin
                    errors++;
                    $display("FAIL bus_stable actual=%0h required=%0h",
                             {iomem_addr, iomem_wdata, iomem_wstrb}, bus_q[$]);
                end
            end
            if (vrun == r_delay) begin
                iomem_ready = 1'b1;
                iomem_rdata = r_data;
            end else begin
                iomem_ready = 1'b0;
                iomem_rdata = $urandom;
            end
            vrun++;
        end
    end

    // response sink: drives rsp_ready, collects bytes, checks hold-while-stalled
    always @(negedge CLKOUT) begin
        if (rsp_valid) begin
            checks++;
            if (cmd_ready) begin
                errors++;
                $display("FAIL cmd_ready_in_resp actual=1 required=0");
            end
            if (prev_stall) begin
                checks++;
                if (rsp_data !== prev_data) begin
                    errors++;
                    $display("FAIL rsp_hold actual=%0h required=%0h", rsp_data, prev_data);
                end
            end
        end
        if (rsp_valid && bp_hold > 0) begin
            rsp_ready = 1'b0;
            bp_hold--;
        end else begin
            rsp_ready = bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (rsp_valid && rsp_ready) got_q.push_back(rsp_data);
        prev_stall = resetn && rsp_valid && !rsp_ready;
        prev_data  = rsp_data;
    end

    // driver tasks (called at a falling edge)
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_data  = b;
        while (!cmd_ready && n < 200) begin
            @(negedge CLKOUT);
            n++;
        end
        if (!cmd_ready) begin
            errors++;
            $display("FAIL cmd_ready_wait actual=0 required=1");
        end
        @(negedge CLKOUT);
        cmd_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        send_byte(op);
        if (op == 8'h52 || op == 8'h57) begin
            for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8]);
            if (op == 8'h57)
                for (int i = 3; i >= 0; i--) send_byte(wdata[i*8 +: 8]);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 500) begin
            @(negedge CLKOUT);
            n++;
        end
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic clear_logs();
        got_q.delete();
        bus_q.delete();
        vlen_q.delete();
        exp_q.delete();
    endtask

    // reference model: frame-level outcome from opcode, responder delay and read data
    task automatic model(input logic [7:0] op, input int delay, input logic [31:0] rdata,
                         output int n, output logic [39:0] rsp, output bit bus, output int vlen);
        if (op != 8'h52 && op != 8'h57) begin
            n = 1; rsp = {8'h3F, 32'h0}; bus = 1'b0; vlen = 0;
        end else begin
            bus = 1'b1;
            if (delay < TMO) begin
                vlen = delay + 1;
                if (op == 8'h57) begin n = 1; rsp = {8'h06, 32'h0}; end
                else begin n = 5; rsp = {8'h06, rdata}; end
            end else begin
                vlen = TMO; n = 1; rsp = {8'h15, 32'h0};
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata, input int n, input logic [39:0] rsp,
                               input bit bus, input int vlen);
        logic [67:0] tx;
        logic [7:0]  act;
        for (int i = 0; i < n; i++) exp_q.push_back(rsp[39-8*i -: 8]);
        chk({tag, "_rsp_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            act = (i < got_q.size()) ? got_q[i] : 8'hxx;
            chk($sformatf("%s_rsp%0d", tag, i), 64'(act), 64'(exp_q[i]));
        end
        chk({tag, "_bus_cnt"}, 64'(bus_q.size()), 64'(bus));
        if (bus && bus_q.size() > 0) begin
            tx = bus_q[0];
            chk({tag, "_addr"}, 64'(tx[67:36]), 64'(addr));
            chk({tag, "_wstrb"}, 64'(tx[3:0]), (op == 8'h57) ? 64'hF : 64'h0);
            if (op == 8'h57) chk({tag, "_wdata"}, 64'(tx[35:4]), 64'(wdata));
        end
        chk({tag, "_vlen_cnt"}, 64'(vlen_q.size()), 64'(bus));
        if (bus && vlen_q.size() > 0) chk({tag, "_vlen"}, 64'(vlen_q[0]), 64'(vlen));
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        int          n_rsp;
        logic [39:0] rsp;
        bit          bus;
        int          vlen;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          n, vlen;
        logic [39:0] rsp;
        bit          bus;
        logic [7:0]  op;
        logic [31:0] addr, wdata, rdata;
        int          delay, k;

        vecs[0] = '{8'h57, 32'h03000000, 32'h0000A55A, 1,  32'h0,        1, {8'h06, 32'h0},        1'b1, 2};
        vecs[1] = '{8'h52, 32'h03000000, 32'h0,        1,  32'h12345678, 5, {8'h06, 32'h12345678}, 1'b1, 2};
        vecs[2] = '{8'h52, 32'hDEAD0000, 32'h0,        99, 32'h0,        1, {8'h15, 32'h0},        1'b1, 8};
        vecs[3] = '{8'h41, 32'h0,        32'h0,        1,  32'h0,        1, {8'h3F, 32'h0},        1'b0, 0};
        vecs[4] = '{8'h52, 32'h00000010, 32'h0,        7,  32'hA1B2C3D4, 5, {8'h06, 32'hA1B2C3D4}, 1'b1, 8};
        vecs[5] = '{8'h57, 32'h00000020, 32'h11223344, 8,  32'h0,        1, {8'h15, 32'h0},        1'b1, 8};
        vecs[6] = '{8'h57, 32'hFFFFFFFC, 32'h00000000, 0,  32'h0,        1, {8'h06, 32'h0},        1'b1, 1};

        // reset values
        repeat (3) @(negedge CLKOUT);
        chk("rst_valid", 64'(iomem_valid), 64'd0);
        chk("rst_wstrb", 64'(iomem_wstrb), 64'd0);
        chk("rst_addr", 64'(iomem_addr), 64'd0);
        chk("rst_wdata", 64'(iomem_wdata), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        resetn = 1'b1;
        @(negedge CLKOUT);
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // directed table
        for (int i = 0; i < 7; i++) begin
            clear_logs();
            r_delay = vecs[i].delay;
            r_data  = vecs[i].rdata;
            send_frame(vecs[i].op, vecs[i].addr, vecs[i].wdata);
            wait_idle($sformatf("vec%0d", i));
            check_frame($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
                        vecs[i].n_rsp, vecs[i].rsp, vecs[i].bus, vecs[i].vlen);
        end

        // backpressure on a read response with a stray command byte offered meanwhile
        clear_logs();
        r_delay = 2;
        r_data  = 32'hCAFEF00D;
        bp_hold = 10;
        send_frame(8'h52, 32'h00001234, 32'h0);
        cmd_valid = 1'b1;
        cmd_data  = 8'h41;
        k = 0;
        while (!rsp_valid && k < 100) begin
            @(negedge CLKOUT);
            k++;
        end
        repeat (3) @(negedge CLKOUT);
        cmd_valid = 1'b0;
        wait_idle("bp");
        check_frame("bp", 8'h52, 32'h00001234, 32'h0, 5, {8'h06, 32'hCAFEF00D}, 1'b1, 3);
        chk("bp_hold_used", 64'(bp_hold), 64'd0);

        // reset during the third bus cycle
        clear_logs();
        r_delay = 1000;
        send_frame(8'h52, 32'h40000000, 32'h0);
        repeat (2) @(negedge CLKOUT);
        chk("midrst_valid_before", 64'(iomem_valid), 64'd1);
        resetn = 1'b0;
        @(negedge CLKOUT);
        chk("midrst_valid", 64'(iomem_valid), 64'd0);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        resetn = 1'b1;
        repeat (4) @(negedge CLKOUT);
        chk("midrst_no_bytes", 64'(got_q.size()), 64'd0);
        clear_logs();
        r_delay = 1;
        send_frame(8'h57, 32'h00000100, 32'hDEADBEEF);
        wait_idle("after_rst");
        check_frame("after_rst", 8'h57, 32'h00000100, 32'hDEADBEEF, 1, {8'h06, 32'h0}, 1'b1, 2);

        // random frames against the model, with random rsp_ready backpressure
        bp_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            if (k < 4) op = 8'h52;
            else if (k < 8) op = 8'h57;
            else begin
                op = 8'($urandom_range(0, 255));
                if (op == 8'h52 || op == 8'h57) op = 8'h00;
            end
            addr  = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            delay = $urandom_range(0, 10);
            model(op, delay, rdata, n, rsp, bus, vlen);
            clear_logs();
            r_delay = delay;
            r_data  = rdata;
            send_frame(op, addr, wdata);
            wait_idle($sformatf("rnd%0d", i));
            check_frame($sformatf("rnd%0d", i), op, addr, wdata, n, rsp, bus, vlen);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
